// File: rtl/ex_alu_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_alu_branch_unit
//  Purpose  : EX-stage datapath of the 5-stage ARM pipeline. It contains:
//             - a 16-op ARM ALU with NZCV generation
//             - the NZCV flag register
//             - the condition tester
//             - the branch-target adder
//             - the branch/link condition handler
//  Revision : 1.0 - initial release
// ============================================================================
module ex_alu_branch_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Shifter_C,
    input  logic [3:0]       ALU_Op,
    input  logic             S_Enable,
    input  logic [3:0]       Cond,
    input  logic             B_Instr,
    input  logic             BL_Instr,
    input  logic [WIDTH-1:0] PC4,
    input  logic [23:0]      Imm24,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [3:0]       Flags_Out,
    output logic [3:0]       CC_Out,
    output logic             Cond_True,
    output logic [WIDTH-1:0] Target_Addr,
    output logic             T_Addr_Sel,
    output logic             BL_Reg
);

    localparam logic [3:0] c_OP_AND = 4'h0;
    localparam logic [3:0] c_OP_EOR = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_RSB = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_ADC = 4'h5;
    localparam logic [3:0] c_OP_SBC = 4'h6;
    localparam logic [3:0] c_OP_RSC = 4'h7;
    localparam logic [3:0] c_OP_TST = 4'h8;
    localparam logic [3:0] c_OP_TEQ = 4'h9;
    localparam logic [3:0] c_OP_CMP = 4'hA;
    localparam logic [3:0] c_OP_CMN = 4'hB;
    localparam logic [3:0] c_OP_ORR = 4'hC;
    localparam logic [3:0] c_OP_MOV = 4'hD;
    localparam logic [3:0] c_OP_BIC = 4'hE;
    localparam logic [3:0] c_OP_MVN = 4'hF;

    // Current carry and overflow held in the flag register.
    logic             w_cc_c;
    logic             w_cc_v;

    // Shared adder. Every subtraction is expressed as x + ~y + cin.
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic             w_is_arith;
    logic [WIDTH:0]   w_sum;

    // ALU result before flag generation.
    logic [WIDTH-1:0] w_result;
    logic             w_c;
    logic             w_v;

    assign w_cc_c = CC_Out[1];
    assign w_cc_v = CC_Out[0];

    // Select adder operands and carry-in for the arithmetic opcodes.
    always_comb begin
        w_add_x    = A;
        w_add_y    = B;
        w_add_cin  = 1'b0;
        w_is_arith = 1'b1;
        case (ALU_Op)
            c_OP_SUB, c_OP_CMP: begin
                w_add_y   = ~B;
                w_add_cin = 1'b1;
            end
            c_OP_RSB: begin
                w_add_x   = B;
                w_add_y   = ~A;
                w_add_cin = 1'b1;
            end
            c_OP_ADD, c_OP_CMN: begin
                w_add_cin = 1'b0;
            end
            c_OP_ADC: begin
                w_add_cin = w_cc_c;
            end
            c_OP_SBC: begin
                w_add_y   = ~B;
                w_add_cin = w_cc_c;
            end
            c_OP_RSC: begin
                w_add_x   = B;
                w_add_y   = ~A;
                w_add_cin = w_cc_c;
            end
            default: w_is_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};

    // Compute the result and C/V. Logical ops take C from the shifter and keep V.
    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        w_c      = w_sum[WIDTH];
        // Overflow: both operands share a sign and the sum's sign differs from it.
        w_v      = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
        if (!w_is_arith) begin
            w_c = Shifter_C;
            w_v = w_cc_v;
            case (ALU_Op)
                c_OP_AND, c_OP_TST: w_result = A & B;
                c_OP_EOR, c_OP_TEQ: w_result = A ^ B;
                c_OP_ORR:           w_result = A | B;
                c_OP_MOV:           w_result = B;
                c_OP_BIC:           w_result = A & ~B;
                c_OP_MVN:           w_result = ~B;
                default:            w_result = A & B;
            endcase
        end
    end

    assign ALU_Out   = w_result;
    assign Flags_Out = {w_result[WIDTH-1], (w_result == '0), w_c, w_v};

    // Flag register: asynchronous clear; loads this op's flags only when S is set.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            CC_Out <= 4'b0000;
        end else if (S_Enable) begin
            CC_Out <= Flags_Out;
        end
    end

    // Evaluate the condition field against the flags of earlier instructions.
    always_comb begin
        Cond_True = 1'b0;
        case (Cond)
            4'h0: Cond_True = CC_Out[2];
            4'h1: Cond_True = !CC_Out[2];
            4'h2: Cond_True = CC_Out[1];
            4'h3: Cond_True = !CC_Out[1];
            4'h4: Cond_True = CC_Out[3];
            4'h5: Cond_True = !CC_Out[3];
            4'h6: Cond_True = CC_Out[0];
            4'h7: Cond_True = !CC_Out[0];
            4'h8: Cond_True = CC_Out[1] && !CC_Out[2];
            4'h9: Cond_True = !CC_Out[1] || CC_Out[2];
            4'hA: Cond_True = (CC_Out[3] == CC_Out[0]);
            4'hB: Cond_True = (CC_Out[3] != CC_Out[0]);
            4'hC: Cond_True = !CC_Out[2] && (CC_Out[3] == CC_Out[0]);
            4'hD: Cond_True = CC_Out[2] || (CC_Out[3] != CC_Out[0]);
            4'hE: Cond_True = 1'b1;
            default: Cond_True = 1'b0;
        endcase
    end

    // Branch target: word offset, sign-extended to the datapath width.
    assign Target_Addr = PC4 + {{(WIDTH-26){Imm24[23]}}, Imm24, 2'b00};
    assign T_Addr_Sel  = B_Instr & Cond_True;
    assign BL_Reg      = BL_Instr & Cond_True;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_alu_branch_unit
//  Purpose  : Self-checking bench for ex_alu_branch_unit. It applies
//             directed and random vectors and compares the outputs against an
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_alu_branch_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [31:0] A, B, PC4;
    logic        Shifter_C, S_Enable, B_Instr, BL_Instr;
    logic [3:0]  ALU_Op, Cond;
    logic [23:0] Imm24;
    logic [31:0] ALU_Out, Target_Addr;
    logic [3:0]  Flags_Out, CC_Out;
    logic        Cond_True, T_Addr_Sel, BL_Reg;

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  m_cc  = 4'b0000;

    ex_alu_branch_unit #(.WIDTH(32)) u_dut (
        .CLK(CLK), .CLR(CLR), .A(A), .B(B), .Shifter_C(Shifter_C), .ALU_Op(ALU_Op),
        .S_Enable(S_Enable), .Cond(Cond), .B_Instr(B_Instr), .BL_Instr(BL_Instr),
        .PC4(PC4), .Imm24(Imm24), .ALU_Out(ALU_Out), .Flags_Out(Flags_Out),
        .CC_Out(CC_Out), .Cond_True(Cond_True), .Target_Addr(Target_Addr),
        .T_Addr_Sel(T_Addr_Sel), .BL_Reg(BL_Reg)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU evaluated with wide signed and unsigned integer arithmetic.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                    input logic sc, input logic [3:0] cc,
                                    output logic [31:0] res, output logic [3:0] nzcv);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint unsigned ci = longint'(cc[1]);
        longint unsigned bw = 1 - ci;
        longint          s  = 0;
        logic            c  = sc;
        logic            v  = cc[0];
        logic            ar = 1'b1;
        case (op)
            4'h2, 4'hA: begin s = sa - sb;           c = (ua >= ub);      end
            4'h3:       begin s = sb - sa;           c = (ub >= ua);      end
            4'h4, 4'hB: begin s = sa + sb;           c = (ua + ub) >= 64'h1_0000_0000; end
            4'h5:       begin s = sa + sb + longint'(ci); c = (ua + ub + ci) >= 64'h1_0000_0000; end
            4'h6:       begin s = sa - sb - longint'(bw); c = (ua >= ub + bw); end
            4'h7:       begin s = sb - sa - longint'(bw); c = (ub >= ua + bw); end
            default:    ar = 1'b0;
        endcase
        if (ar) begin
            res = s[31:0];
            v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (op)
                4'h0, 4'h8: res = a & b;
                4'h1, 4'h9: res = a ^ b;
                4'hC:       res = a | b;
                4'hD:       res = b;
                4'hE:       res = a & ~b;
                default:    res = ~b;
            endcase
        end
        nzcv = {res[31], res == 32'd0, c, v};
    endfunction

    function automatic logic ref_cond(input logic [3:0] cd, input logic [3:0] f);
        logic n = f[3], z = f[2], c = f[1], v = f[0];
        case (cd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one vector, check the combinational outputs, clock it, then check the flag register.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic sc, input logic [3:0] op,
                         input logic s, input logic [3:0] cd, input logic bi, input logic bli,
                         input logic [31:0] pc4, input logic [23:0] imm);
        logic [31:0] res;
        logic [3:0]  f;
        logic        ct;
        longint      tgt;
        @(negedge CLK);
        A = a; B = b; Shifter_C = sc; ALU_Op = op; S_Enable = s; Cond = cd;
        B_Instr = bi; BL_Instr = bli; PC4 = pc4; Imm24 = imm;
        #1;
        ref_alu(a, b, op, sc, m_cc, res, f);
        ct  = ref_cond(cd, m_cc);
        tgt = longint'(pc4) + 4 * longint'($signed(imm));
        chk("alu_out",   ALU_Out,             res);
        chk("flags_out", {28'd0, Flags_Out},  {28'd0, f});
        chk("cond_true", {31'd0, Cond_True},  {31'd0, ct});
        chk("target",    Target_Addr,         tgt[31:0]);
        chk("t_sel",     {31'd0, T_Addr_Sel}, {31'd0, bi & ct});
        chk("bl_reg",    {31'd0, BL_Reg},     {31'd0, bli & ct});
        @(posedge CLK);
        if (s) m_cc = f;
        #1;
        chk("cc_out",    {28'd0, CC_Out},     {28'd0, m_cc});
    endtask

    initial begin
        CLR = 1'b0; A = '0; B = '0; Shifter_C = 1'b0; ALU_Op = '0; S_Enable = 1'b0;
        Cond = 4'hE; B_Instr = 1'b0; BL_Instr = 1'b0; PC4 = '0; Imm24 = '0;
        #2;
        chk("reset_cc", {28'd0, CC_Out}, 32'd0);
        @(negedge CLK);
        CLR = 1'b1;

        // Directed cases, including the overflow, equal-compare and carry-chain corners.
        apply(32'h7FFFFFFF, 32'h1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b0, 1'b0, 32'h0, 24'h0);
        chk("add_ovf_cc", {28'd0, CC_Out}, 32'h9);
        apply(32'd5, 32'd5, 1'b0, 4'hA, 1'b1, 4'h1, 1'b0, 1'b0, 32'h0, 24'h0);
        chk("cmp_eq_cc", {28'd0, CC_Out}, 32'h6);
        apply(32'd0, 32'd0, 1'b0, 4'hD, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100, 24'hFFFFFE);
        chk("beq_taken", {31'd0, T_Addr_Sel}, 32'd1);
        chk("tgt_back", Target_Addr, 32'hF8);
        apply(32'hFFFFFFFF, 32'd0, 1'b0, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0, 32'h100, 24'h000002);
        chk("adc_wrap", {28'd0, CC_Out}, 32'h6);
        apply(32'd0, 32'd0, 1'b0, 4'hD, 1'b1, 4'hE, 1'b0, 1'b0, 32'h0, 24'h0);
        apply(32'd5, 32'd3, 1'b0, 4'h6, 1'b0, 4'hE, 1'b0, 1'b1, 32'h100, 24'h000002);
        chk("sbc_res", ALU_Out, 32'd1);
        chk("bl_al", {31'd0, BL_Reg}, 32'd1);
        apply(32'hFF, 32'h0F, 1'b1, 4'hE, 1'b0, 4'hE, 1'b0, 1'b0, 32'h0, 24'h0);
        chk("bic_res", ALU_Out, 32'hF0);
        apply(32'h0, 32'h0, 1'b1, 4'hF, 1'b1, 4'hE, 1'b0, 1'b0, 32'h0, 24'h0);
        chk("mvn_cc", {28'd0, CC_Out}, 32'hA);

        // Random traffic over every opcode and condition code.
        for (int i = 0; i < 300; i++) begin
            apply($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), $urandom, 24'($urandom));
        end

        // Drive nonzero flags into the register, then clear it asynchronously between edges.
        apply(32'h80000000, 32'h80000000, 1'b0, 4'h4, 1'b1, 4'hE, 1'b0, 1'b0, 32'h0, 24'h0);
        @(negedge CLK);
        S_Enable = 1'b0; Cond = 4'h1; B_Instr = 1'b1; BL_Instr = 1'b0;
        #2;
        CLR = 1'b0;
        #1;
        m_cc = 4'b0000;
        chk("async_clr", {28'd0, CC_Out}, 32'd0);
        chk("ne_after_clr", {31'd0, T_Addr_Sel}, 32'd1);
        Cond = 4'h0;
        #1;
        chk("eq_after_clr", {31'd0, Cond_True}, 32'd0);
        @(negedge CLK);
        CLR = 1'b1;
        apply(32'd1, 32'd2, 1'b0, 4'h2, 1'b0, 4'hE, 1'b1, 1'b1, 32'h2000, 24'h800000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
